// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : IF-stage / IF-ID sequencing: load-use stalls, EX redirects,
//             multi-cycle EX holds and instruction-memory wait handling.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int ARCH_WIDTH   = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int IMEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_busy,
    input  logic                  ex_redirect,
    input  logic [ARCH_WIDTH-1:0] ex_redirect_pc,
    input  logic                  imem_ready,
    output logic                  imem_req,
    output logic                  imem_abort,
    output logic                  pc_en,
    output logic                  pc_sel,
    output logic [ARCH_WIDTH-1:0] redirect_pc,
    output logic                  if_id_en,
    output logic                  if_stall,
    output logic                  flush,
    output logic                  id_ex_bubble,
    output logic                  err
);

    localparam int c_FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int c_WCNT_W = $clog2(IMEM_TIMEOUT + 1);
    localparam bit c_HAS_FLUSH_STATE = (FLUSH_CYCLES > 1);
    localparam logic [c_FCNT_W-1:0] c_FLUSH_LOAD = c_FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [c_WCNT_W-1:0] c_TIMEOUT    = c_WCNT_W'(IMEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_RUN       = 3'd1,
        S_FLUSH     = 3'd2,
        S_IMEM_WAIT = 3'd3,
        S_ERR       = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_FCNT_W-1:0]   r_fcnt;
    logic [c_FCNT_W-1:0]   w_fcnt_nxt;
    logic [c_WCNT_W-1:0]   r_wcnt;
    logic [c_WCNT_W-1:0]   w_wcnt_nxt;
    logic [c_WCNT_W-1:0]   w_wcnt_inc;
    logic [ARCH_WIDTH-1:0] r_redirect_pc;
    logic                  r_err;

    logic w_lu;
    logic w_take_redirect;
    logic w_rpc_load;
    logic w_err_set;
    logic w_req;
    logic w_abort;
    logic w_pc_en;
    logic w_pc_sel;
    logic w_if_id_en;
    logic w_if_stall;
    logic w_flush;
    logic w_bubble;

    assign w_lu = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign w_wcnt_inc = r_wcnt + 1'b1;

    // A redirect outranks everything in any fetching state except HOLD.
    assign w_take_redirect = ex_redirect &&
                             ((r_state == S_RUN) || (r_state == S_IMEM_WAIT) ||
                              (r_state == S_FLUSH));

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_wcnt_nxt  = r_wcnt;
        w_rpc_load  = 1'b0;
        w_err_set   = 1'b0;
        w_req       = 1'b0;
        w_abort     = 1'b0;
        w_pc_en     = 1'b0;
        w_pc_sel    = 1'b0;
        w_if_id_en  = 1'b0;
        w_if_stall  = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;

        if (w_take_redirect) begin
            w_req      = 1'b1;
            w_pc_en    = 1'b1;
            w_pc_sel   = 1'b1;
            w_if_id_en = 1'b1;
            w_flush    = 1'b1;
            w_bubble   = 1'b1;
            w_abort    = (r_state == S_IMEM_WAIT);
            w_rpc_load = 1'b1;
            w_wcnt_nxt = '0;
            if (c_HAS_FLUSH_STATE) begin
                w_state_nxt = S_FLUSH;
                w_fcnt_nxt  = c_FLUSH_LOAD;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_req       = 1'b1;
                    w_if_id_en  = 1'b1;
                    w_flush     = 1'b1;
                    w_state_nxt = S_RUN;
                end
                S_RUN, S_IMEM_WAIT: begin
                    w_req = 1'b1;
                    // ex_busy freezes everything, including the wait counter.
                    if (!ex_busy) begin
                        w_if_id_en = 1'b1;
                        if (w_lu) begin
                            w_if_stall = 1'b1;
                            w_bubble   = 1'b1;
                        end else if (!imem_ready) begin
                            w_flush = 1'b1;
                        end else begin
                            w_pc_en = 1'b1;
                        end

                        if (!imem_ready) begin
                            w_wcnt_nxt = w_wcnt_inc;
                            if (w_wcnt_inc == c_TIMEOUT) begin
                                w_state_nxt = S_ERR;
                                w_err_set   = 1'b1;
                            end else begin
                                w_state_nxt = S_IMEM_WAIT;
                            end
                        end else begin
                            w_wcnt_nxt  = '0;
                            w_state_nxt = S_RUN;
                        end
                    end
                end
                S_FLUSH: begin
                    w_req      = 1'b1;
                    w_if_id_en = 1'b1;
                    w_flush    = 1'b1;
                    w_pc_en    = imem_ready;
                    if (r_fcnt <= c_FCNT_W'(1)) begin
                        w_fcnt_nxt  = '0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_fcnt_nxt = r_fcnt - 1'b1;
                    end
                end
                S_ERR: begin
                    w_state_nxt = S_ERR;
                end
                default: begin
                    w_state_nxt = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_HOLD;
            r_fcnt        <= '0;
            r_wcnt        <= '0;
            r_redirect_pc <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_rpc_load) begin
                r_redirect_pc <= ex_redirect_pc;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs are forced low for as long as reset is held.
    assign imem_req     = rst_n & w_req;
    assign imem_abort   = rst_n & w_abort;
    assign pc_en        = rst_n & w_pc_en;
    assign pc_sel       = rst_n & w_pc_sel;
    assign if_id_en     = rst_n & w_if_id_en;
    assign if_stall     = rst_n & w_if_stall;
    assign flush        = rst_n & w_flush;
    assign id_ex_bubble = rst_n & w_bubble;
    assign redirect_pc  = r_redirect_pc;
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES = 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    // Expected-output bit order: req abort pc_en pc_sel if_id_en if_stall flush bubble err
    localparam logic [8:0] c_ZERO   = 9'h000;
    localparam logic [8:0] c_HOLD   = 9'h114;
    localparam logic [8:0] c_WAIT   = 9'h114;
    localparam logic [8:0] c_RUN    = 9'h150;
    localparam logic [8:0] c_STALL  = 9'h11A;
    localparam logic [8:0] c_BUSY   = 9'h100;
    localparam logic [8:0] c_REDIR  = 9'h176;
    localparam logic [8:0] c_REDAB  = 9'h1F6;
    localparam logic [8:0] c_FL_RDY = 9'h154;
    localparam logic [8:0] c_ERR    = 9'h001;
    localparam logic [31:0] c_JUNK  = 32'hDEAD0000;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        busy;
        logic        mrd;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        rdy;
        logic [8:0]  exp;
        logic [31:0] erpc;
    } vec_t;

    typedef struct {
        string       name;
        logic [8:0]  exp;
        logic [31:0] erpc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_busy, ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        imem_ready;
    logic        imem_req, imem_abort, pc_en, pc_sel, if_id_en, if_stall;
    logic        flush, id_ex_bubble, err;
    logic [31:0] redirect_pc;
    logic [8:0]  act;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .ARCH_WIDTH  (32),
        .REG_ADDR_W  (5),
        .FLUSH_CYCLES(2),
        .IMEM_TIMEOUT(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .ex_busy       (ex_busy),
        .ex_redirect   (ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .imem_abort    (imem_abort),
        .pc_en         (pc_en),
        .pc_sel        (pc_sel),
        .redirect_pc   (redirect_pc),
        .if_id_en      (if_id_en),
        .if_stall      (if_stall),
        .flush         (flush),
        .id_ex_bubble  (id_ex_bubble),
        .err           (err)
    );

    assign act = {imem_req, imem_abort, pc_en, pc_sel, if_id_en, if_stall,
                  flush, id_ex_bubble, err};

    task automatic add(input string name, input logic rn, input logic redir,
                       input logic [31:0] rpc, input logic busy, input logic mrd,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rdy,
                       input logic [8:0] exp, input logic [31:0] erpc);
        vec_t v;
        v.name = name; v.rst_n = rn; v.redir = redir; v.rpc = rpc; v.busy = busy;
        v.mrd = mrd; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rdy = rdy; v.exp = exp; v.erpc = erpc;
        tbl.push_back(v);
    endtask

    // Plain cycle: no hazard inputs, only reset/ready/busy/redirect vary.
    task automatic add_s(input string name, input logic rn, input logic redir,
                         input logic [31:0] rpc, input logic busy, input logic rdy,
                         input logic [8:0] exp, input logic [31:0] erpc);
        add(name, rn, redir, rpc, busy, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, rdy, exp, erpc);
    endtask

    // Drive one vector after the rising edge, then check it on the falling edge.
    task automatic apply(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        rst_n          = v.rst_n;
        ex_redirect    = v.redir;
        ex_redirect_pc = v.rpc;
        ex_busy        = v.busy;
        ex_mem_read    = v.mrd;
        ex_rd          = v.rd;
        id_rs1         = v.rs1;
        id_rs2         = v.rs2;
        id_uses_rs1    = v.u1;
        id_uses_rs2    = v.u2;
        imem_ready     = v.rdy;
        sb.push_back('{v.name, v.exp, v.erpc});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", e.name, act, e.exp);
        end
        checks++;
        if (redirect_pc !== e.erpc) begin
            errors++;
            $display("FAIL %s redirect_pc: got %h expected %h", e.name, redirect_pc, e.erpc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = '0; ex_busy = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; imem_ready = 1'b1;

        //      name             rn redir rpc           busy mrd rd  rs1 rs2 u1 u2 rdy exp       erpc
        add_s("rst_idle",        0, 0, c_JUNK,         0, 1, c_ZERO, 32'h0);
        add  ("rst_active_in",   0, 1, 32'h40,         1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, c_ZERO, 32'h0);
        add_s("hold",            1, 0, c_JUNK,         0, 1, c_HOLD, 32'h0);
        add_s("run",             1, 0, c_JUNK,         0, 1, c_RUN, 32'h0);
        add  ("lu_rs2",          1, 0, c_JUNK,         0, 1, 5'd5, 5'd3, 5'd5, 1, 1, 1, c_STALL, 32'h0);
        add  ("lu_rd_x0",        1, 0, c_JUNK,         0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1, c_RUN, 32'h0);
        add  ("lu_rs1",          1, 0, c_JUNK,         0, 1, 5'd7, 5'd7, 5'd2, 1, 1, 1, c_STALL, 32'h0);
        add  ("rs1_unused",      1, 0, c_JUNK,         0, 1, 5'd7, 5'd7, 5'd2, 0, 1, 1, c_RUN, 32'h0);
        add  ("not_a_load",      1, 0, c_JUNK,         0, 0, 5'd7, 5'd7, 5'd2, 1, 1, 1, c_RUN, 32'h0);
        add  ("busy_lu_a",       1, 0, c_JUNK,         1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, c_BUSY, 32'h0);
        add  ("busy_lu_b",       1, 0, c_JUNK,         1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, c_BUSY, 32'h0);
        add  ("lu_after_busy",   1, 0, c_JUNK,         0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, c_STALL, 32'h0);
        add_s("run2",            1, 0, c_JUNK,         0, 1, c_RUN, 32'h0);
        add_s("redirect",        1, 1, 32'h100,        0, 1, c_REDIR, 32'h0);
        add_s("flush_ready",     1, 0, c_JUNK,         0, 1, c_FL_RDY, 32'h100);
        add_s("run_after_fl",    1, 0, c_JUNK,         0, 1, c_RUN, 32'h100);
        add_s("wait1",           1, 0, c_JUNK,         0, 0, c_WAIT, 32'h100);
        add_s("wait2",           1, 0, c_JUNK,         0, 0, c_WAIT, 32'h100);
        add_s("wait3",           1, 0, c_JUNK,         0, 0, c_WAIT, 32'h100);
        add_s("wait_done",       1, 0, c_JUNK,         0, 1, c_RUN, 32'h100);
        add_s("wait4",           1, 0, c_JUNK,         0, 0, c_WAIT, 32'h100);
        add_s("redir_abort",     1, 1, 32'h180,        0, 0, c_REDAB, 32'h100);
        add_s("flush_not_ready", 1, 0, c_JUNK,         0, 0, c_WAIT, 32'h180);
        add_s("redir_run",       1, 1, 32'h200,        0, 1, c_REDIR, 32'h180);
        add_s("redir_in_flush",  1, 1, 32'h300,        0, 1, c_REDIR, 32'h200);
        add_s("flush_ready2",    1, 0, c_JUNK,         0, 1, c_FL_RDY, 32'h300);
        add_s("run3",            1, 0, c_JUNK,         0, 1, c_RUN, 32'h300);
        add  ("lu_not_ready",    1, 0, c_JUNK,         0, 1, 5'd9, 5'd9, 5'd1, 1, 0, 0, c_STALL, 32'h300);
        add_s("wait5",           1, 0, c_JUNK,         0, 0, c_WAIT, 32'h300);
        add_s("busy_in_wait",    1, 0, c_JUNK,         1, 0, c_BUSY, 32'h300);
        add_s("wait_done2",      1, 0, c_JUNK,         0, 1, c_RUN, 32'h300);

        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();

        // Timeout: 8 waits, 3 busy cycles (counter frozen), 8 more waits -> ERR.
        for (int i = 0; i < 8; i++)  add_s("to_wait_a", 1, 0, c_JUNK, 0, 0, c_WAIT, 32'h300);
        for (int i = 0; i < 3; i++)  add_s("to_busy",   1, 0, c_JUNK, 1, 0, c_BUSY, 32'h300);
        for (int i = 0; i < 8; i++)  add_s("to_wait_b", 1, 0, c_JUNK, 0, 0, c_WAIT, 32'h300);
        add_s("err_entered",     1, 0, c_JUNK,  0, 1, c_ERR, 32'h300);
        add_s("err_redir_ign",   1, 1, 32'h400, 0, 1, c_ERR, 32'h300);
        add_s("err_sticky",      1, 0, c_JUNK,  0, 1, c_ERR, 32'h300);
        // Reset mid-operation clears err and redirect_pc at once, then HOLD.
        add_s("mid_reset",       0, 0, c_JUNK,  0, 1, c_ZERO, 32'h0);
        add_s("hold_again",      1, 0, c_JUNK,  0, 1, c_HOLD, 32'h0);
        add_s("run_again",       1, 0, c_JUNK,  0, 1, c_RUN, 32'h0);

        foreach (tbl[i]) apply(tbl[i]);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
